// File: rtl/truth_sweep_checker.sv
// truth_sweep_checker
//   Purpose : walks every input vector {A,B,C,D,...} into a combinational function block,
//             waits a settle time, then compares each group's direct/SOP/POS outputs and
//             records how many (vector, group) pairs disagree and where the first one was.
//   Latency : start to done = 2**N_IN*(SETTLE+2) + 1 clk; done is a registered 1-cycle pulse.
//   Flow    : start is honoured only in IDLE; pulses while busy (or on the FINISH cycle) are dropped.
//   Ports   : clk, reset (async, active high), start -> busy/done/pass, vec_out drives the DUT,
//             grp_in = {direct,sop,pos} per group, err_cnt / first_err_vec / first_err_grp report.
//   Option  : TRUTH_LOG_EN adds truth_log, one bit per (group, vector) holding the direct output.
module truth_sweep_checker #(
   parameter int N_IN   = 4,
   parameter int N_GRP  = 3,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [N_IN-1:0]      vec_out,
   input  logic [3*N_GRP-1:0]   grp_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [N_IN-1:0]      first_err_vec,
   output logic [N_GRP-1:0]     first_err_grp
`ifdef TRUTH_LOG_EN
   ,
   output logic [N_GRP*(2**N_IN)-1:0] truth_log
`endif
);

   localparam int N_VEC = 2 ** N_IN;
   localparam int SUM_W = CNT_W + 4;   // room for err_cnt plus a popcount of up to 8 groups
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
   localparam logic [3:0]       WAIT_LD  = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_ADVANCE,
      S_FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         wait_q, wait_d;
   logic [N_IN-1:0]    vec_q, vec_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [N_IN-1:0]    fvec_q, fvec_d;
   logic [N_GRP-1:0]   fgrp_q, fgrp_d;
   logic [N_GRP-1:0]   mm;
   logic [SUM_W-1:0]   pop;
   logic [SUM_W-1:0]   sum;
`ifdef TRUTH_LOG_EN
   logic [N_GRP*N_VEC-1:0] log_q, log_d;
`endif

   // Per-group disagreement between the three forms, and how many groups disagree.
   always_comb begin
      mm  = '0;
      pop = '0;
      for (int g = 0; g < N_GRP; g++) begin
         mm[g] = !((grp_in[3*g+2] == grp_in[3*g+1]) && (grp_in[3*g+1] == grp_in[3*g]));
         pop   = pop + SUM_W'(mm[g]);
      end
      sum = SUM_W'(err_q) + pop;
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fgrp_d  = fgrp_q;
`ifdef TRUTH_LOG_EN
      log_d   = log_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = '0;
               fvec_d  = '0;
               fgrp_d  = '0;
               pass_d  = 1'b0;
               vec_d   = '0;
               busy_d  = 1'b1;
               wait_d  = WAIT_LD;
               state_d = S_SETTLE;
`ifdef TRUTH_LOG_EN
               log_d   = '0;
`endif
            end
         end
         S_SETTLE: begin
            if (wait_q == 4'd0) state_d = S_SAMPLE;
            else                wait_d  = wait_q - 4'd1;
         end
         S_SAMPLE: begin
            err_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
            // err_cnt only grows, so zero here means no mismatch seen yet this sweep.
            if ((err_q == '0) && (mm != '0)) begin
               fvec_d = vec_q;
               fgrp_d = mm;
            end
`ifdef TRUTH_LOG_EN
            for (int g = 0; g < N_GRP; g++) begin
               log_d[g*N_VEC + int'(vec_q)] = grp_in[3*g+2];
            end
`endif
            state_d = (vec_q == VEC_LAST) ? S_FINISH : S_ADVANCE;
         end
         S_ADVANCE: begin
            vec_d   = vec_q + N_IN'(1);
            wait_d  = WAIT_LD;
            state_d = S_SETTLE;
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_q == '0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fvec_q  <= '0;
         fgrp_q  <= '0;
`ifdef TRUTH_LOG_EN
         log_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fgrp_q  <= fgrp_d;
`ifdef TRUTH_LOG_EN
         log_q   <= log_d;
`endif
      end
   end

   assign vec_out       = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_q;
   assign first_err_vec = fvec_q;
   assign first_err_grp = fgrp_q;
`ifdef TRUTH_LOG_EN
   assign truth_log     = log_q;
`endif

endmodule

// File: tb/tb_truth_sweep_checker.sv
// Bench for truth_sweep_checker: three instances share start/reset.
//   u_dut : defaults (4 inputs, 3 groups, SETTLE 2, 8-bit counter), fault injection by mode
//   u_sat : same but CNT_W=5 so the all-wrong sweep saturates the counter
//   u_one : single group, SETTLE 3, always-correct parity function
module tb_truth_sweep_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   int          mode;

   logic [3:0]  vec_main, vec_sat, vec_one;
   logic [8:0]  grp_main, grp_sat;
   logic [2:0]  grp_one;
   logic        busy_main, done_main, pass_main;
   logic        busy_sat,  done_sat,  pass_sat;
   logic        busy_one,  done_one,  pass_one;
   logic [7:0]  err_main, err_one;
   logic [4:0]  err_sat;
   logic [3:0]  fvec_main, fvec_sat, fvec_one;
   logic [2:0]  fgrp_main, fgrp_sat;
   logic [0:0]  fgrp_one;
`ifdef TRUTH_LOG_EN
   logic [47:0] log_main, log_sat;
   logic [15:0] log_one;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int lat_main, lat_one, nd_main, nd_sat, nd_one;
   logic busy_mid;

   always #5 clk = ~clk;

   // Reference functions: A=v[3], B=v[2], C=v[1], D=v[0].
   function automatic logic fn(input int g, input logic [3:0] v);
      case (g)
         0:       return v[3] & v[2];
         1:       return ^v;
         default: return v[2] | v[0];
      endcase
   endfunction

   // {direct, sop, pos}; mode 1 breaks group 1 POS at vector 5, mode 2 breaks every SOP.
   function automatic logic [2:0] grp_bits(input int g, input logic [3:0] v, input int md);
      logic d, s, p;
      d = fn(g, v);
      s = d;
      p = d;
      if (md == 1 && g == 1 && v == 4'd5) p = ~d;
      if (md == 2) s = ~d;
      return {d, s, p};
   endfunction

   always_comb begin
      grp_main = '0;
      grp_sat  = '0;
      for (int g = 0; g < 3; g++) begin
         grp_main[3*g +: 3] = grp_bits(g, vec_main, mode);
         grp_sat[3*g +: 3]  = grp_bits(g, vec_sat, mode);
      end
      grp_one = grp_bits(1, vec_one, 0);
   end

   truth_sweep_checker u_dut (
      .clk(clk), .reset(reset), .start(start), .vec_out(vec_main), .grp_in(grp_main),
      .busy(busy_main), .done(done_main), .pass(pass_main), .err_cnt(err_main),
      .first_err_vec(fvec_main), .first_err_grp(fgrp_main)
`ifdef TRUTH_LOG_EN
      , .truth_log(log_main)
`endif
   );

   truth_sweep_checker #(.N_IN(4), .N_GRP(3), .SETTLE(2), .CNT_W(5)) u_sat (
      .clk(clk), .reset(reset), .start(start), .vec_out(vec_sat), .grp_in(grp_sat),
      .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_cnt(err_sat),
      .first_err_vec(fvec_sat), .first_err_grp(fgrp_sat)
`ifdef TRUTH_LOG_EN
      , .truth_log(log_sat)
`endif
   );

   truth_sweep_checker #(.N_IN(4), .N_GRP(1), .SETTLE(3), .CNT_W(8)) u_one (
      .clk(clk), .reset(reset), .start(start), .vec_out(vec_one), .grp_in(grp_one),
      .busy(busy_one), .done(done_one), .pass(pass_one), .err_cnt(err_one),
      .first_err_vec(fvec_one), .first_err_grp(fgrp_one)
`ifdef TRUTH_LOG_EN
      , .truth_log(log_one)
`endif
   );

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulses start (accepted at the first posedge), then runs 100 cycles. Extra start
   // pulses are sampled at posedge number x1 / x2 after acceptance. Latency counts the
   // start cycle, so done seen at posedge i means latency i+1.
   task automatic run_sweep(input int x1, input int x2);
      lat_main = 0; lat_one = 0; nd_main = 0; nd_sat = 0; nd_one = 0; busy_mid = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk); start = (i == x1) || (i == x2);
         @(posedge clk); #1;
         if (i == 10) busy_mid = busy_main;
         if (done_main) begin nd_main++; if (lat_main == 0) lat_main = i + 1; end
         if (done_sat)  nd_sat++;
         if (done_one)  begin nd_one++;  if (lat_one == 0)  lat_one = i + 1;  end
      end
      @(negedge clk); start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_val({tag, "_vec"},  vec_main,  4'd0);
      chk_val({tag, "_busy"}, busy_main, 1'b0);
      chk_val({tag, "_done"}, done_main, 1'b0);
      chk_val({tag, "_pass"}, pass_main, 1'b0);
      chk_val({tag, "_err"},  err_main,  8'd0);
      chk_val({tag, "_fvec"}, fvec_main, 4'd0);
      chk_val({tag, "_fgrp"}, fgrp_main, 3'd0);
   endtask

   initial begin
      logic hit;
      int   nd_after;
      reset = 1'b1;
      start = 1'b0;
      mode  = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      @(negedge clk); reset = 1'b0;

      // 1: all functions correct.
      run_sweep(-1, -1);
      chk_val("t1_latency",     lat_main, 65);      // 16*(2+2)+1
      chk_val("t1_latency_one", lat_one,  81);      // 16*(3+2)+1
      chk_val("t1_busy_mid",    busy_mid, 1'b1);
      chk_val("t1_pass",        pass_main, 1'b1);
      chk_val("t1_err",         err_main, 8'd0);
      chk_val("t1_fvec",        fvec_main, 4'd0);
      chk_val("t1_pass_one",    pass_one, 1'b1);
      chk_val("t1_err_one",     err_one, 8'd0);
      chk_val("t1_vec_hold",    vec_main, 4'hF);
      chk_val("t1_busy_end",    busy_main, 1'b0);
`ifdef TRUTH_LOG_EN
      chk_val("t6_log_main",    log_main, {16'hFAFA, 16'h6996, 16'hF000});
      chk_val("t6_log_one",     log_one, 16'h6996);
`endif

      // 2 + 5: group 1 POS wrong at vector 5, with stray starts mid-sweep and on FINISH.
      mode = 1;
      run_sweep(10, 64);
      chk_val("t2_err",         err_main, 8'd1);
      chk_val("t2_fvec",        fvec_main, 4'd5);
      chk_val("t2_fgrp",        fgrp_main, 3'b010);
      chk_val("t2_pass",        pass_main, 1'b0);
      chk_val("t5_latency",     lat_main, 65);
      chk_val("t5_ndone",       nd_main, 1);
      chk_val("t5_ndone_sat",   nd_sat, 1);
      chk_val("t5_ndone_one",   nd_one, 1);
      chk_val("t5_idle_after",  busy_main, 1'b0);

      // 3: every SOP wrong -> 48 mismatches; 5-bit counter saturates at 31.
      mode = 2;
      run_sweep(-1, -1);
      chk_val("t3_err",         err_main, 8'd48);
      chk_val("t3_err_sat",     err_sat, 5'd31);
      chk_val("t3_pass_sat",    pass_sat, 1'b0);
      chk_val("t3_fvec",        fvec_main, 4'd0);
      chk_val("t3_fgrp",        fgrp_main, 3'b111);
      chk_val("t3_pass",        pass_main, 1'b0);

      // 4: reset asserted while vector 7 is on the bus.
      mode = 1;
      hit  = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(posedge clk); #1;
         if (vec_main == 4'd7) hit = 1'b1;
      end
      chk_val("t4_reach_vec7", hit, 1'b1);
      reset = 1'b1;
      #1;
      chk_reset_vals("t4_async");
      @(negedge clk); @(negedge clk); reset = 1'b0;
      nd_after = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (done_main || done_sat || done_one) nd_after++;
      end
      chk_val("t4_no_done", nd_after, 0);
      chk_reset_vals("t4_after");

      run_sweep(-1, -1);
      chk_val("t4_resweep_lat",  lat_main, 65);
      chk_val("t4_resweep_err",  err_main, 8'd1);
      chk_val("t4_resweep_fvec", fvec_main, 4'd5);
      chk_val("t4_resweep_fgrp", fgrp_main, 3'b010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
